// File: rtl/binary_to_onehot_pkg.sv
// Types and encode function for the binary-to-one-hot stream encoder.
package binary_to_onehot_pkg;
  localparam int STATE_W  = onehot_to_binary_pkg::STATE_W;
  localparam int BIN_W    = $clog2(STATE_W);
  localparam int ERRCNT_W = 8;

  typedef struct packed {
    logic               err;
    logic [STATE_W-1:0] onehot;
  } onehot_word_t;

  // Bit 0 = main entry valid, bit 1 = skid entry valid, so both flags come straight off flops.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_FULL  = 2'b11
  } buf_state_e;

  function automatic onehot_word_t enc_onehot(input logic [BIN_W-1:0] bin);
    onehot_word_t w;
    w.err = (int'(bin) >= STATE_W);
    for (int k = 0; k < STATE_W; k++) begin
      w.onehot[k] = (int'(bin) == k);
    end
    return w;
  endfunction
endpackage

// File: rtl/onehot_to_binary_pkg.sv
// Shared one-hot state width used by the one-hot/binary converter pair.
package onehot_to_binary_pkg;
  localparam int STATE_W = 6;
endpackage

// File: rtl/binary_to_onehot_stream_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; 1-cycle latency, outputs are pure flops.
// Backpressure: in_ready_o is the registered "skid empty" flag, no path from out_ready_i.
module onehot_skid_buf
  import binary_to_onehot_pkg::*;
#(
  parameter type T = onehot_word_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o
);
  buf_state_e state_q, state_d;
  T           main_q, main_d;
  T           skid_q, skid_d;
  logic       accept;

  assign in_ready_o  = rst_ni & ~state_q[1];
  assign out_valid_o = state_q[0];
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_o;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && out_ready_i) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = BUF_FULL;
        end else if (out_ready_i) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_ready_i) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
endmodule

// File: rtl/binary_to_onehot_stream.sv
// Streaming binary index -> registered one-hot encoder with out-of-range flag, 1-cycle latency.
// Full-rate valid/ready via skid buffer; BINARY_TO_ONEHOT_ERRCNT_EN adds a saturating error counter.
module binary_to_onehot_stream
  import binary_to_onehot_pkg::*;
#(
  parameter int STATE_W  = binary_to_onehot_pkg::STATE_W,
  parameter int ERRCNT_W = binary_to_onehot_pkg::ERRCNT_W,
  localparam int BIN_W = $clog2(STATE_W)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [BIN_W-1:0]   bin_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] onehot_o,
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
  output logic [ERRCNT_W-1:0] errcnt_o,
  input  logic                errcnt_clr_i,
`endif
  output logic               err_o
);
  typedef struct packed {
    logic               err;
    logic [STATE_W-1:0] onehot;
  } word_t;

  word_t enc_word;
  word_t out_word;

  // Shared encoder for the package width; an equivalent local loop covers other widths.
  if (STATE_W == binary_to_onehot_pkg::STATE_W) begin : g_pkg_enc
    assign enc_word = enc_onehot(bin_i);
  end else begin : g_local_enc
    always_comb begin
      enc_word     = '0;
      enc_word.err = (int'(bin_i) >= STATE_W);
      for (int k = 0; k < STATE_W; k++) begin
        enc_word.onehot[k] = (int'(bin_i) == k);
      end
    end
  end

  onehot_skid_buf #(
    .T (word_t)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (enc_word),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_word)
  );

  assign onehot_o = out_word.onehot;
  assign err_o    = out_word.err;

`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
  logic                err_accept;

  assign err_accept = in_valid_i & in_ready_o & enc_word.err;
  assign errcnt_o   = errcnt_q;

  // A clear coinciding with a bad word still records that word.
  always_comb begin
    errcnt_d = errcnt_q;
    if (errcnt_clr_i) begin
      errcnt_d = ERRCNT_W'(err_accept);
    end else if (err_accept && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      errcnt_q <= '0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_binary_to_onehot_stream.sv
// Self-checking bench for binary_to_onehot_stream: directed table, hand sequences, random vs FIFO model.
module tb_binary_to_onehot_stream;
  localparam int SW = 6;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          out_ready_i = 1'b0;
  logic [2:0]    bin_i = '0;
  logic          in_ready_o;
  logic          out_valid_o;
  logic          err_o;
  logic [SW-1:0] onehot_o;
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
  logic          errcnt_clr_i = 1'b0;
  logic [CW-1:0] errcnt_o;
`endif

  always #5 clk_i = ~clk_i;

  binary_to_onehot_stream #(
    .STATE_W  (SW),
    .ERRCNT_W (CW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .bin_i        (bin_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .onehot_o     (onehot_o),
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    .errcnt_o     (errcnt_o),
    .errcnt_clr_i (errcnt_clr_i),
`endif
    .err_o        (err_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the following rising edge.
  task automatic drive(input logic v, input logic [2:0] b, input logic r);
    in_valid_i  = v;
    bin_i       = b;
    out_ready_i = r;
    @(posedge clk_i);
    #1;
  endtask

  typedef struct packed {
    logic          err;
    logic [SW-1:0] oh;
  } word_t;

  function automatic word_t ref_enc(input int k);
    word_t w;
    w.err = (k >= SW);
    w.oh  = (k < SW) ? (SW'(1) << k) : '0;
    return w;
  endfunction

  typedef struct {
    logic          v;
    logic [2:0]    b;
    logic          r;
    logic          ev;
    logic [SW-1:0] eoh;
    logic          eerr;
    logic          erdy;
    logic          chkdat;
    int            ecnt;
  } vec_t;

  vec_t  tbl[14];
  word_t q[$];
  int    ecnt_m;
  int    accepted;
  int    cyc;
  logic  v, r, clr, acc, xfer;
  logic [2:0] b;

  initial begin
    tbl[0]  = '{1'b1, 3'd0, 1'b1, 1'b1, 6'b000001, 1'b0, 1'b1, 1'b1, 0};
    tbl[1]  = '{1'b1, 3'd1, 1'b1, 1'b1, 6'b000010, 1'b0, 1'b1, 1'b1, 0};
    tbl[2]  = '{1'b1, 3'd2, 1'b1, 1'b1, 6'b000100, 1'b0, 1'b1, 1'b1, 0};
    tbl[3]  = '{1'b1, 3'd3, 1'b1, 1'b1, 6'b001000, 1'b0, 1'b1, 1'b1, 0};
    tbl[4]  = '{1'b1, 3'd4, 1'b1, 1'b1, 6'b010000, 1'b0, 1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 3'd5, 1'b1, 1'b1, 6'b100000, 1'b0, 1'b1, 1'b1, 0};
    tbl[6]  = '{1'b1, 3'd6, 1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 1'b1, 1};
    tbl[7]  = '{1'b1, 3'd7, 1'b1, 1'b1, 6'b000000, 1'b1, 1'b1, 1'b1, 2};
    tbl[8]  = '{1'b0, 3'd0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0, 2};
    tbl[9]  = '{1'b1, 3'd2, 1'b0, 1'b1, 6'b000100, 1'b0, 1'b1, 1'b1, 2};
    tbl[10] = '{1'b1, 3'd3, 1'b0, 1'b1, 6'b000100, 1'b0, 1'b0, 1'b1, 2};
    tbl[11] = '{1'b1, 3'd4, 1'b0, 1'b1, 6'b000100, 1'b0, 1'b0, 1'b1, 2};
    tbl[12] = '{1'b0, 3'd0, 1'b1, 1'b1, 6'b001000, 1'b0, 1'b1, 1'b1, 2};
    tbl[13] = '{1'b0, 3'd0, 1'b1, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0, 2};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'(0));
    chk("rst_onehot", 32'(onehot_o), 32'(0));
    chk("rst_err", 32'(err_o), 32'(0));
    chk("rst_in_ready", 32'(in_ready_o), 32'(0));
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    chk("rst_errcnt", 32'(errcnt_o), 32'(0));
`endif
    rst_ni = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready_o), 32'(1));

    // Directed table: in-range sweep, out-of-range words, backpressure fill and drain
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].b, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid_o), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready_o), 32'(tbl[i].erdy));
      if (tbl[i].chkdat) begin
        chk($sformatf("tbl%0d_onehot", i), 32'(onehot_o), 32'(tbl[i].eoh));
        chk($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].eerr));
      end
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
      chk($sformatf("tbl%0d_errcnt", i), 32'(errcnt_o), 32'(tbl[i].ecnt));
`endif
    end

    // Saturation of the error counter, then clear with and without a coincident bad word
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(6 + (i % 2)), 1'b1);
      chk($sformatf("sat%0d_err", i), 32'(err_o), 32'(1));
      chk($sformatf("sat%0d_onehot", i), 32'(onehot_o), 32'(0));
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
      chk($sformatf("sat%0d_errcnt", i), 32'(errcnt_o), 32'((i + 3 > 3) ? 3 : i + 3));
`endif
    end
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    errcnt_clr_i = 1'b1;
    drive(1'b1, 3'd6, 1'b1);
    chk("clr_hit_errcnt", 32'(errcnt_o), 32'(1));
    drive(1'b0, 3'd0, 1'b1);
    chk("clr_idle_errcnt", 32'(errcnt_o), 32'(0));
    errcnt_clr_i = 1'b0;
`else
    drive(1'b0, 3'd0, 1'b1);
`endif

    // Fill to FULL, then a one-cycle reset discards both entries
    drive(1'b1, 3'd7, 1'b0);
    drive(1'b1, 3'd1, 1'b0);
    chk("full_in_ready", 32'(in_ready_o), 32'(0));
    chk("full_err_held", 32'(err_o), 32'(1));
    in_valid_i = 1'b0;
    rst_ni     = 1'b0;
    @(posedge clk_i);
    #1;
    chk("midrst_valid", 32'(out_valid_o), 32'(0));
    chk("midrst_onehot", 32'(onehot_o), 32'(0));
    chk("midrst_err", 32'(err_o), 32'(0));
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    chk("midrst_errcnt", 32'(errcnt_o), 32'(0));
`endif
    rst_ni = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready_o), 32'(1));
    drive(1'b0, 3'd0, 1'b1);
    chk("postrst_valid", 32'(out_valid_o), 32'(0));

    // Random valid/ready traffic against a depth-2 FIFO model
    q.delete();
    ecnt_m   = 0;
    accepted = 0;
    cyc      = 0;
    while (accepted < 1000 && cyc < 20000) begin
      chk("rnd_valid", 32'(out_valid_o), 32'(q.size() > 0));
      chk("rnd_in_ready", 32'(in_ready_o), 32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_onehot", 32'(onehot_o), 32'(q[0].oh));
        chk("rnd_err", 32'(err_o), 32'(q[0].err));
      end
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
      chk("rnd_errcnt", 32'(errcnt_o), 32'(ecnt_m));
`endif
      v    = ($urandom_range(0, 9) < 7);
      r    = ($urandom_range(0, 9) < 6);
      b    = 3'($urandom_range(0, 7));
      clr  = ($urandom_range(0, 49) == 0);
      acc  = v && (q.size() < 2);
      xfer = r && (q.size() > 0);
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
      errcnt_clr_i = clr;
`endif
      drive(v, b, r);
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_enc(int'(b)));
        accepted++;
      end
      if (clr) ecnt_m = (acc && b >= 3'(SW)) ? 1 : 0;
      else if (acc && b >= 3'(SW) && ecnt_m < 3) ecnt_m++;
      cyc++;
    end
    if (accepted < 1000) chk("rnd_budget", 32'(accepted), 32'(1000));
`ifdef BINARY_TO_ONEHOT_ERRCNT_EN
    errcnt_clr_i = 1'b0;
`endif

    // Drain whatever the model still holds
    cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      chk("drain_valid", 32'(out_valid_o), 32'(1));
      chk("drain_onehot", 32'(onehot_o), 32'(q[0].oh));
      chk("drain_err", 32'(err_o), 32'(q[0].err));
      drive(1'b0, 3'd0, 1'b1);
      void'(q.pop_front());
      cyc++;
    end
    chk("drain_empty", 32'(out_valid_o), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/binary_to_onehot_stream.md
Name: binary_to_onehot_stream

Overview:
Streaming binary-to-one-hot encoder, the inverse of the team's one-hot-to-binary decoder. It accepts binary state indices on a valid/ready input channel and emits registered one-hot vectors on a valid/ready output channel. A 2-entry skid buffer sustains full throughput and registers every output. Out-of-range indices are flagged rather than silently dropped. It sits between the FSM/scheduler logic that produces indices and the one-hot-select datapaths.

Parameters:
STATE_W, default onehot_to_binary_pkg::STATE_W, one-hot vector width (>=2; need not be a power of two).
BIN_W, default $clog2(STATE_W), binary index width; derived, never overridden.
ERRCNT_W, default 8, width of the saturating error counter (used only with the optional feature).

Ports:
clk_i  input  1  clock; all logic rising-edge.
rst_ni  input  1  reset, synchronous, active-low.
in_valid_i  input  1  input word valid.
in_ready_o  output  1  block can accept an input word.
bin_i  input  BIN_W  binary index.
out_valid_o  output  1  output word valid.
out_ready_i  input  1  downstream accepts the output word.
onehot_o  output  STATE_W  one-hot vector.
err_o  output  1  accompanies onehot_o; 1 = index was out of range.
errcnt_o  output  ERRCNT_W  saturating count of out-of-range words (present only with the optional feature).
errcnt_clr_i  input  1  synchronous clear of errcnt_o (present only with the optional feature).

Behaviour:
- Reset is synchronous and active-low: while rst_ni=0 at a clock edge, out_valid_o=0, onehot_o=0, err_o=0 and the skid entry is emptied. in_ready_o=0 while rst_ni=0. in_ready_o=1 on the first cycle after release.
- Input handshake: a word transfers when in_valid_i & in_ready_o at a rising edge. Output handshake: a word transfers when out_valid_o & out_ready_i.
- Encoding: for an accepted bin_i=k < STATE_W, onehot_o[k]=1, all other bits 0, err_o=0. For k >= STATE_W, onehot_o=0 and err_o=1. Encoding is done before the register, so outputs are pure flops.
- Latency: 1 cycle from input accept to out_valid_o when the output stage is empty or draining.
- Storage has two states: main register (drives outputs) and skid register.
  - EMPTY -> ONE on accept.
  - ONE + accept + out_ready_i: stays ONE, main reloaded.
  - ONE + accept + !out_ready_i: goes FULL, word parked in skid.
  - FULL -> ONE on out_ready_i; skid moves to main.
  - ONE -> EMPTY on out_ready_i with no accept.
- in_ready_o = !skid_valid, registered. No combinational path from out_ready_i to in_ready_o.
- Ordering: strict FIFO. Word payload and err_o stay stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o never drops without an output transfer (except on reset).
- When out_valid_o=0, onehot_o and err_o hold their last value (don't-care for checkers). Reset value is 0.
- Reset mid-operation discards both entries. No partial output.
- Invariant: $onehot0(onehot_o), and err_o=1 implies onehot_o=0.

Optional Feature:
Macro BINARY_TO_ONEHOT_ERRCNT_EN.
- Defined: errcnt_o and errcnt_clr_i exist.
  - The counter increments by 1 on each input accept with bin_i >= STATE_W and saturates at 2^ERRCNT_W-1.
  - errcnt_clr_i=1 sets the count to 0, or to 1 if an out-of-range accept occurs in the same cycle.
  - Reset value is 0.
- Undefined: both ports and the counter are absent. err_o behaviour is unchanged.

Decomposition:
- Package binary_to_onehot_pkg: imports STATE_W from onehot_to_binary_pkg and holds:
  - BIN_W, ERRCNT_W.
  - typedef onehot_word_t, a packed struct {logic err; logic [STATE_W-1:0] onehot;}.
  - function enc_onehot(bin) returning onehot_word_t.
- One sub-module, onehot_skid_buf: a generic 2-entry valid/ready skid buffer over onehot_word_t. The top module instantiates it after the enc_onehot function and adds the error counter.

Test Plan:
1. STATE_W=6, out_ready_i=1, bin_i 0..5 on consecutive cycles -> onehot_o 000001, 000010 ... 100000 one cycle later each, err_o=0, in_ready_o stays 1.
2. bin_i=6 then 7 -> onehot_o=000000 with err_o=1 for both. With macro defined, errcnt_o=2.
3. out_ready_i=0, push bin_i=2, 3 -> out_valid_o=1 with 000100 held, in_ready_o=0 after the second accept. Then raise out_ready_i -> 000100, then 001000, in order, no loss.
4. Random valid/ready toggling, 1000 words -> output sequence equals the model sequence, no duplicates, stability under backpressure holds.
5. ERRCNT_W=2, five out-of-range words -> errcnt_o saturates at 3. errcnt_clr_i coincident with an out-of-range accept -> errcnt_o=1.
6. rst_ni=0 for one cycle while FULL -> next cycle out_valid_o=0, onehot_o=0, in_ready_o=1, errcnt_o=0.
